// File: rtl/weapon_attack_ctrl.sv
// -----------------------------------------------------------------------------
// weapon_attack_ctrl
//
// Player weapon attack sequencer. A rising edge of the left mouse button starts
// a melee swing (offset ramps up to SWING_MAX and back, one step per frame) or
// an archer draw (DRAW_FRAMES frames, then a one-cycle arrow launch). Every
// attack ends in a COOLDOWN lockout of COOLDOWN_FRAMES frames. Losing the game,
// dying or switching class mid-attack aborts straight back to IDLE.
//
// Ports
//   clk            : the only clock
//   rst_n          : asynchronous active-low reset
//   frame_tick     : one-cycle pulse per video frame
//   mouse_left     : raw left-button level
//   game_active    : game is running when nonzero
//   alive          : player alive
//   char_class     : 01 melee, 10 archer, anything else unarmed
//   boss_alive     : boss alive
//   melee_hit      : weapon/boss overlap level from the renderer
//   attack_active  : weapon visible (SWING, RETRACT, DRAW, FIRE)
//   anim_x_offset  : melee swing offset in pixels, 0 outside SWING/RETRACT
//   boss_dmg_pulse : one-cycle melee damage event, at most one per swing
//   arrow_fire     : one-cycle arrow launch event
//   busy           : high whenever the sequencer is not IDLE
//   dbg_state      : current state encoding, for debug and checkers
//
// Handshake: there is no valid/ready pair here. Inputs are levels sampled on
// every rising clk edge; boss_dmg_pulse and arrow_fire are single-cycle events
// that the consumer must capture in the cycle they are high, with no back-
// pressure.
//
// SWING_MAX must be a nonzero multiple of SWING_STEP, and DRAW_FRAMES and
// COOLDOWN_FRAMES must be at least 1.
// -----------------------------------------------------------------------------
module weapon_attack_ctrl #(
  parameter int SWING_STEP      = 4,
  parameter int SWING_MAX       = 24,
  parameter int DRAW_FRAMES     = 12,
  parameter int COOLDOWN_FRAMES = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        mouse_left,
  input  logic [1:0]  game_active,
  input  logic        alive,
  input  logic [1:0]  char_class,
  input  logic        boss_alive,
  input  logic        melee_hit,
  output logic        attack_active,
  output logic [11:0] anim_x_offset,
  output logic        boss_dmg_pulse,
  output logic        arrow_fire,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Counter must hold the larger of the two frame loads.
  localparam int CNT_MAX = (DRAW_FRAMES > COOLDOWN_FRAMES) ? DRAW_FRAMES : COOLDOWN_FRAMES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [1:0]    CLASS_MELEE  = 2'b01;
  localparam logic [1:0]    CLASS_ARCHER = 2'b10;
  localparam logic [11:0]   STEP         = 12'(SWING_STEP);
  localparam logic [11:0]   PEAK         = 12'(SWING_MAX);
  localparam logic [CW-1:0] DRAW_LOAD    = CW'(DRAW_FRAMES);
  localparam logic [CW-1:0] COOL_LOAD    = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SWING    = 3'd1,
    S_RETRACT  = 3'd2,
    S_DRAW     = 3'd3,
    S_FIRE     = 3'd4,
    S_COOLDOWN = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_dn;
  logic [11:0]   offset, offset_nx, off_up, off_dn;
  logic          hit_done, hit_done_nx;
  logic          pulse_nx;
  logic          mouse_q;
  logic          click;
  logic          in_melee, in_ranged;
  logic          abort;
  logic          hit_now;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    click     = mouse_left & ~mouse_q;
    in_melee  = (state == S_SWING) || (state == S_RETRACT);
    in_ranged = (state == S_DRAW)  || (state == S_FIRE);

    // Class is checked against the class implied by the attack in progress,
    // so a change away from it during the weapon-visible phases aborts.
    // COOLDOWN tolerates a class change; the lockout simply runs out.
    abort = (game_active == 2'b00) || !alive
         || (in_melee  && (char_class != CLASS_MELEE))
         || (in_ranged && (char_class != CLASS_ARCHER));

    // Only the first overlap of a swing counts.
    hit_now = in_melee && !hit_done && melee_hit && boss_alive;

    off_up = offset + STEP;
    off_dn = offset - STEP;
    cnt_dn = cnt - CNT_ONE;

    state_nx    = state;
    cnt_nx      = cnt;
    offset_nx   = offset;
    hit_done_nx = hit_done;
    pulse_nx    = 1'b0;

    if (abort) begin
      // Abort wins over frame_tick, clicks and any pending hit.
      state_nx    = S_IDLE;
      cnt_nx      = '0;
      offset_nx   = '0;
      hit_done_nx = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A tick in this same cycle is deliberately not applied to the new
          // state; advancing starts with the next tick.
          if (click && (char_class == CLASS_MELEE)) begin
            state_nx    = S_SWING;
            offset_nx   = '0;
            hit_done_nx = 1'b0;
            cnt_nx      = '0;
          end else if (click && (char_class == CLASS_ARCHER)) begin
            state_nx = S_DRAW;
            cnt_nx   = DRAW_LOAD;
          end
        end

        S_SWING: begin
          if (hit_now) begin
            pulse_nx    = 1'b1;
            hit_done_nx = 1'b1;
          end
          if (frame_tick) begin
            offset_nx = off_up;
            if (off_up == PEAK) state_nx = S_RETRACT;
          end
        end

        S_RETRACT: begin
          if (hit_now) begin
            pulse_nx    = 1'b1;
            hit_done_nx = 1'b1;
          end
          if (frame_tick) begin
            offset_nx = off_dn;
            if (off_dn == '0) begin
              state_nx = S_COOLDOWN;
              cnt_nx   = COOL_LOAD;
            end
          end
        end

        S_DRAW: begin
          if (frame_tick) begin
            cnt_nx = cnt_dn;
            if (cnt_dn == '0) state_nx = S_FIRE;
          end
        end

        S_FIRE: begin
          // Exactly one cycle regardless of frame_tick.
          state_nx = S_COOLDOWN;
          cnt_nx   = COOL_LOAD;
        end

        S_COOLDOWN: begin
          // Clicks fall through unused here and are not remembered.
          if (frame_tick) begin
            cnt_nx = cnt_dn;
            if (cnt_dn == '0) state_nx = S_IDLE;
          end
        end

        default: begin
          state_nx    = S_IDLE;
          cnt_nx      = '0;
          offset_nx   = '0;
          hit_done_nx = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Outputs are decoded from the next state so
  // they line up with the state register in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      offset         <= '0;
      hit_done       <= 1'b0;
      mouse_q        <= 1'b0;
      boss_dmg_pulse <= 1'b0;
      arrow_fire     <= 1'b0;
      attack_active  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      offset         <= offset_nx;
      hit_done       <= hit_done_nx;
      mouse_q        <= mouse_left;
      boss_dmg_pulse <= pulse_nx;
      arrow_fire     <= (state_nx == S_FIRE);
      attack_active  <= (state_nx == S_SWING) || (state_nx == S_RETRACT)
                     || (state_nx == S_DRAW)  || (state_nx == S_FIRE);
      busy           <= (state_nx != S_IDLE);
    end
  end

  // offset is forced to 0 on every path out of SWING/RETRACT, so it can drive
  // the port directly.
  assign anim_x_offset = offset;
  assign dbg_state     = state;

endmodule

// File: tb/tb_weapon_attack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weapon_attack_ctrl
//
// Bench for weapon_attack_ctrl with default parameters. The reference model
// tracks an attack as "kind + frames elapsed since start" and derives the
// expected offset, visibility, busy and events from closed-form arithmetic.
// -----------------------------------------------------------------------------
module tb_weapon_attack_ctrl;

  localparam int STEP = 4;
  localparam int PEAK = 24;
  localparam int DRAW = 12;
  localparam int COOL = 20;
  localparam int NSW  = PEAK / STEP;   // ticks to reach the peak

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        mouse_left;
  logic [1:0]  game_active;
  logic        alive;
  logic [1:0]  char_class;
  logic        boss_alive;
  logic        melee_hit;
  logic        attack_active;
  logic [11:0] anim_x_offset;
  logic        boss_dmg_pulse;
  logic        arrow_fire;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_vec;
  int n_err;

  weapon_attack_ctrl #(
    .SWING_STEP(STEP), .SWING_MAX(PEAK), .DRAW_FRAMES(DRAW), .COOLDOWN_FRAMES(COOL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .mouse_left(mouse_left),
    .game_active(game_active), .alive(alive), .char_class(char_class),
    .boss_alive(boss_alive), .melee_hit(melee_hit), .attack_active(attack_active),
    .anim_x_offset(anim_x_offset), .boss_dmg_pulse(boss_dmg_pulse),
    .arrow_fire(arrow_fire), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: kind 0 none, 1 melee, 2 archer; t = frames elapsed in the
  // current phase (melee: since start; archer: in draw, then in cooldown).
  // ---------------------------------------------------------------------------
  int m_kind;
  int m_t;
  bit m_in_fire;
  bit m_fired;
  bit m_hit_used;
  bit m_pulse;
  bit m_prev_mouse;

  function automatic void model_reset();
    m_kind = 0; m_t = 0; m_in_fire = 0; m_fired = 0;
    m_hit_used = 0; m_pulse = 0; m_prev_mouse = 0;
  endfunction

  function automatic void model_step();
    bit click_e;
    bit abort_e;
    bit new_pulse;
    click_e      = mouse_left && !m_prev_mouse;
    m_prev_mouse = mouse_left;
    new_pulse    = 0;
    abort_e = (game_active == 2'b00) || !alive
           || (m_kind == 1 && m_t < 2*NSW && char_class != 2'b01)
           || (m_kind == 2 && !m_fired && char_class != 2'b10);
    if (abort_e) begin
      m_kind = 0;
    end else if (m_kind == 0) begin
      if (click_e && char_class == 2'b01) begin
        m_kind = 1; m_t = 0; m_hit_used = 0;
      end else if (click_e && char_class == 2'b10) begin
        m_kind = 2; m_t = 0; m_in_fire = 0; m_fired = 0;
      end
    end else if (m_kind == 1) begin
      if (m_t < 2*NSW && !m_hit_used && melee_hit && boss_alive) begin
        new_pulse = 1; m_hit_used = 1;
      end
      if (frame_tick) m_t++;
      if (m_t == 2*NSW + COOL) m_kind = 0;
    end else begin
      if (m_in_fire) begin
        m_in_fire = 0; m_fired = 1; m_t = 0;
      end else if (frame_tick) begin
        m_t++;
        if (!m_fired && m_t == DRAW) m_in_fire = 1;
        else if (m_fired && m_t == COOL) m_kind = 0;
      end
    end
    m_pulse = new_pulse;
  endfunction

  function automatic logic exp_busy();
    return (m_kind != 0);
  endfunction

  function automatic logic exp_active();
    return (m_kind == 1 && m_t < 2*NSW) || (m_kind == 2 && !m_fired);
  endfunction

  function automatic logic [11:0] exp_offset();
    if (m_kind == 1 && m_t < 2*NSW)
      return (m_t <= NSW) ? 12'(m_t * STEP) : 12'((2*NSW - m_t) * STEP);
    return 12'd0;
  endfunction

  function automatic logic exp_fire();
    return (m_kind == 2) && m_in_fire;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // One frame: tick for a cycle, then two quiet cycles.
  task automatic frame();
    frame_tick = 1'b1; cycle();
    frame_tick = 1'b0; cycle(); cycle();
  endtask

  task automatic click();
    mouse_left = 1'b1; cycle();
    mouse_left = 1'b0; cycle();
  endtask

  task automatic defaults();
    frame_tick = 0; mouse_left = 0; game_active = 2'b01; alive = 1;
    char_class = 2'b01; boss_alive = 1; melee_hit = 0;
  endtask

  // Abort to IDLE through a one-cycle death.
  task automatic flush();
    alive = 1'b0; cycle(); alive = 1'b1; cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    defaults();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (attack_active !== 1'b0) begin n_err++; $display("FAIL reset_active got %0b want 0", attack_active); end
    n_vec++; if (anim_x_offset !== 12'd0) begin n_err++; $display("FAIL reset_offset got %0d want 0", anim_x_offset); end
    n_vec++; if (boss_dmg_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse got %0b want 0", boss_dmg_pulse); end
    n_vec++; if (arrow_fire !== 1'b0) begin n_err++; $display("FAIL reset_fire got %0b want 0", arrow_fire); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_melee();
    int active_frames;
    defaults();
    click();
    n_vec++; if (busy !== 1'b1 || anim_x_offset !== 12'd0) begin n_err++; $display("FAIL melee_start busy=%0b off=%0d want busy=1 off=0", busy, anim_x_offset); end
    active_frames = 0;
    for (int i = 1; i <= 2*NSW; i++) begin
      if (attack_active === 1'b1) active_frames++;
      frame();
      n_vec++; if (anim_x_offset !== exp_offset()) begin n_err++; $display("FAIL melee_offset frame %0d got %0d want %0d", i, anim_x_offset, exp_offset()); end
      n_vec++; if (attack_active !== exp_active()) begin n_err++; $display("FAIL melee_active frame %0d got %0b want %0b", i, attack_active, exp_active()); end
    end
    n_vec++; if (active_frames != 2*NSW || attack_active !== 1'b0) begin n_err++; $display("FAIL melee_active_frames got %0d (now %0b) want %0d (now 0)", active_frames, attack_active, 2*NSW); end
    for (int i = 1; i <= COOL; i++) begin
      frame();
      n_vec++; if (busy !== exp_busy()) begin n_err++; $display("FAIL melee_cooldown frame %0d busy got %0b want %0b", i, busy, exp_busy()); end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL melee_release busy got %0b want 0", busy); end
  endtask

  task automatic test_hit();
    int pulses;
    defaults();
    for (int pass = 0; pass < 2; pass++) begin
      boss_alive = (pass == 0);
      click();
      pulses = 0;
      melee_hit = 1'b1;
      for (int c = 0; c < 30; c++) begin
        cycle();
        if (boss_dmg_pulse === 1'b1) pulses++;
        n_vec++; if (boss_dmg_pulse !== m_pulse) begin n_err++; $display("FAIL hit_pulse boss=%0b cyc %0d got %0b want %0b", boss_alive, c, boss_dmg_pulse, m_pulse); end
        if (c == 0) begin
          n_vec++; if (boss_dmg_pulse !== boss_alive) begin n_err++; $display("FAIL hit_latency boss=%0b got %0b want %0b", boss_alive, boss_dmg_pulse, boss_alive); end
        end
      end
      melee_hit = 1'b0;
      n_vec++; if (pulses != int'(boss_alive)) begin n_err++; $display("FAIL hit_count boss=%0b got %0d want %0d", boss_alive, pulses, int'(boss_alive)); end
      flush();
    end
  endtask

  task automatic test_archer();
    int fires;
    bit clicked;
    defaults();
    char_class = 2'b10;
    click();
    fires = 0; clicked = 0;
    for (int c = 0; c < 200 && m_kind != 0; c++) begin
      frame_tick = (c % 3 == 0);
      mouse_left = (m_fired && m_t == 5 && !clicked);
      if (mouse_left) clicked = 1;
      cycle();
      if (arrow_fire === 1'b1) fires++;
      n_vec++; if (arrow_fire !== exp_fire() || busy !== exp_busy() || attack_active !== exp_active())
        begin n_err++; $display("FAIL archer cyc %0d fire/busy/act got %0b%0b%0b want %0b%0b%0b", c, arrow_fire, busy, attack_active, exp_fire(), exp_busy(), exp_active()); end
    end
    frame_tick = 0; mouse_left = 0;
    n_vec++; if (fires != 1 || !clicked) begin n_err++; $display("FAIL archer_fire_count got %0d want 1", fires); end
    cycle();
    n_vec++; if (busy !== 1'b0 || m_kind != 0) begin n_err++; $display("FAIL archer_end busy got %0b want 0", busy); end
  endtask

  task automatic test_abort();
    defaults();
    click();
    repeat (4) frame();
    n_vec++; if (anim_x_offset !== 12'd16) begin n_err++; $display("FAIL abort_pre offset got %0d want 16", anim_x_offset); end
    alive = 1'b0; cycle(); alive = 1'b1;
    n_vec++; if (anim_x_offset !== 12'd0 || attack_active !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL abort_idle off=%0d act=%0b busy=%0b want 0 0 0", anim_x_offset, attack_active, busy); end
    click();
    n_vec++; if (anim_x_offset !== 12'd0 || busy !== 1'b1) begin n_err++; $display("FAIL abort_restart off=%0d busy=%0b want 0 1", anim_x_offset, busy); end
    frame();
    n_vec++; if (anim_x_offset !== 12'd4) begin n_err++; $display("FAIL abort_fresh offset got %0d want 4", anim_x_offset); end
    char_class = 2'b10; cycle();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_class busy got %0b want 0", busy); end
    flush();
  endtask

  task automatic test_hold_class();
    int starts;
    logic prev_busy;
    defaults();
    mouse_left = 1'b1;
    starts = 0; prev_busy = busy;
    for (int f = 0; f < 100; f++) begin
      frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
      if (busy === 1'b1 && prev_busy === 1'b0) starts++;
      prev_busy = busy;
      cycle(); cycle();
    end
    n_vec++; if (starts != 1) begin n_err++; $display("FAIL hold_attacks got %0d want 1", starts); end
    mouse_left = 1'b0; cycle();
    for (int k = 0; k < 2; k++) begin
      char_class = (k == 0) ? 2'b00 : 2'b11;
      click(); cycle();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL class_ignored class=%0d busy got %0b want 0", char_class, busy); end
    end
  endtask

  task automatic test_reset_mid();
    defaults();
    click();
    repeat (NSW + 2) frame();
    n_vec++; if (anim_x_offset !== 12'(PEAK - 2*STEP)) begin n_err++; $display("FAIL mid_pre offset got %0d want %0d", anim_x_offset, PEAK - 2*STEP); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({attack_active, anim_x_offset, boss_dmg_pulse, arrow_fire, busy} !== 16'd0)
      begin n_err++; $display("FAIL mid_reset act=%0b off=%0d pulse=%0b fire=%0b busy=%0b want all 0", attack_active, anim_x_offset, boss_dmg_pulse, arrow_fire, busy); end
    model_reset();
    mouse_left = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_first_click busy got %0b want 1", busy); end
    mouse_left = 1'b0;
    flush();
  endtask

  task automatic test_random();
    defaults();
    for (int c = 0; c < 4000; c++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) mouse_left = ~mouse_left;
      if ($urandom_range(0, 199) == 0) char_class = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 59) == 0) char_class = 2'($urandom_range(1, 2));
      game_active = ($urandom_range(0, 299) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      alive       = ($urandom_range(0, 299) != 0);
      melee_hit   = ($urandom_range(0, 5) == 0);
      boss_alive  = ($urandom_range(0, 9) != 0);
      cycle();
      n_vec++; if (anim_x_offset !== exp_offset()) begin n_err++; $display("FAIL rand_offset cyc %0d got %0d want %0d", c, anim_x_offset, exp_offset()); end
      n_vec++; if (attack_active !== exp_active()) begin n_err++; $display("FAIL rand_active cyc %0d got %0b want %0b", c, attack_active, exp_active()); end
      n_vec++; if (busy !== exp_busy()) begin n_err++; $display("FAIL rand_busy cyc %0d got %0b want %0b", c, busy, exp_busy()); end
      n_vec++; if (boss_dmg_pulse !== m_pulse) begin n_err++; $display("FAIL rand_pulse cyc %0d got %0b want %0b", c, boss_dmg_pulse, m_pulse); end
      n_vec++; if (arrow_fire !== exp_fire()) begin n_err++; $display("FAIL rand_fire cyc %0d got %0b want %0b", c, arrow_fire, exp_fire()); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_melee();
    test_hit();
    test_archer();
    test_abort();
    test_hold_class();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
